vga_row_buffer: RTL
===================

VGA_ROW_BUFFER -- requirements
Module: vga_row_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: scan_line_start  in  1  one-cycle pulse at start of hblank of line scan_y.
REQ-004 SHALL have ports: scan_y  in  10  current timing line, 0..`V_TOTAL-1.
REQ-005 SHALL have ports: scan_x  in  10  current display column; disp_en  in  1  active-video flag.
REQ-006 SHALL have ports: y_tl  in  9  VRAM row shown on screen line 0.
REQ-007 SHALL have ports: VGA_re  out  1  row-fetch request to VRAM controller; VGA_y  out  9  VRAM row requested.
REQ-008 SHALL have ports: VGA_we  in  1, VGA_x  in  10, VGA_data  in  24  pixel write from VRAM controller.
REQ-009 SHALL have ports: pix_out  out  24  RGB888 to DAC; fetch_busy  out  1; overrun_err  out  1 sticky.
REQ-010 SHALL use compile-time constants `SCREEN_W (640), `SCREEN_H (480), `V_TOTAL (525) from screen_settings.vh.

Function
REQ-011 SHALL hold two line banks of `SCREEN_W x 24 bits; wr_sel selects fill bank, ~wr_sel scanout bank.
REQ-012 SHALL implement FSM IDLE -> REQ -> FILL -> IDLE; fetch_busy = (state != IDLE).
REQ-013 At scan_line_start in line n: target t = (n+2) mod `V_TOTAL; if t < `SCREEN_H and state IDLE, SHALL enter REQ with VGA_y = (y_tl + t) mod 512, latched.
REQ-014 At same scan_line_start, if state IDLE, SHALL toggle wr_sel when (n+1) mod `V_TOTAL < `SCREEN_H (swap precedes new request).
REQ-015 In REQ, VGA_re SHALL be held 1 until the first VGA_we is seen, then FSM enters FILL; VGA_re 0 in all other states.
REQ-016 Whenever VGA_we=1 and VGA_x < `SCREEN_W, SHALL write VGA_data to fill bank at address VGA_x, in REQ or FILL; writes in IDLE ignored.
REQ-017 Write with VGA_x = `SCREEN_W-1 SHALL return FSM to IDLE the next cycle.
REQ-018 pix_out SHALL equal scanout bank[scan_x] registered one cycle after scan_x/disp_en; 24'd0 when disp_en=0 or scan_x >= `SCREEN_W.
REQ-019 scan_line_start while state != IDLE SHALL set overrun_err, suppress swap and new request, and leave the in-progress fetch running.
REQ-020 Row arithmetic SHALL be 10-bit with explicit wrap at `V_TOTAL; VGA_y sum truncates to 9 bits.

Reset
REQ-021 On rst (sampled at clk): state IDLE, wr_sel 0, VGA_re 0, VGA_y 0, pix_out 0, overrun_err 0, fetch_busy 0.
REQ-022 Reset mid-FILL SHALL abandon the fetch; bank contents undefined, not cleared.

Configuration
REQ-023 Macro VGA_ROW_BUFFER_LINE_DOUBLE_EN defined: row index r = t>>1, VGA_y = (y_tl + r) mod 512; request only when t even; swap only when (n+1) even.
REQ-024 Macro undefined: r = t; request and swap every eligible line per REQ-013/014.

Structure
REQ-025 Package vga_pkg SHALL hold fetch-state enum typedef, bank depth/width localparams, pixel typedef.
REQ-026 One sub-module vga_line_ram (1 write port, 1 registered read port, `SCREEN_W x 24) SHALL be instantiated twice.

Verification
REQ-027 Reset, then scan_line_start with scan_y=0, y_tl=10 -> VGA_re=1, VGA_y=12 next cycle, held until first VGA_we.
REQ-028 Feed 640 writes of VGA_data=x*3 -> state IDLE after x=639; next scan_line_start swaps; scan_x=100 with disp_en -> pix_out=300 one cycle later.
REQ-029 scan_line_start after only 300 writes -> overrun_err=1, wr_sel unchanged, no new VGA_re; fill completes.
REQ-030 scan_y=523 pulse -> t=0, VGA_y=y_tl; scan_y=478 pulse -> t=480, no request.
REQ-031 LINE_DOUBLE_EN defined, y_tl=0: pulses at scan_y=0..3 -> requests only at n=0 (VGA_y=1), n=2 (VGA_y=2).
REQ-032 disp_en=0 or scan_x=700 -> pix_out=0; VGA_we in IDLE -> no bank change.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and sizes for the VGA row buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "screen_settings.vh"

package vga_pkg;

    localparam int BANK_DEPTH = `SCREEN_W;
    localparam int BANK_WIDTH = 24;
    localparam logic [9:0] LAST_X = 10'(`SCREEN_W - 1);

    typedef logic [BANK_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/screen_settings.vh
// Screen geometry shared by the row buffer and its line RAMs.
// 640x480 visible area inside a 525-line frame.
// Guarded so every file may include it independently.
`ifndef SCREEN_SETTINGS_VH
`define SCREEN_SETTINGS_VH
`define SCREEN_W 640
`define SCREEN_H 480
`define V_TOTAL  525
`endif

// File: rtl/vga_line_ram.sv
// One scan-line bank: single write port, single registered read port.
// Latency: read data valid one clk after raddr; writes land on the same edge.
// Backpressure: none, both ports accept every cycle; out-of-range addresses are dropped / read as zero.
`include "screen_settings.vh"

module vga_line_ram
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  pixel_t     wdata,
    input  logic [9:0] raddr,
    output pixel_t     rdata
);

    pixel_t mem [BANK_DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && (waddr < 10'(BANK_DEPTH))) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= (raddr < 10'(BANK_DEPTH)) ? mem[raddr] : '0;
    end

endmodule

// File: rtl/vga_row_buffer.sv
// Double-buffered scan-line store: fetches VRAM row for line n+2 while line n+1 scans out.
// Latency: pix_out one clk after scan_x/disp_en; fetch request one clk after scan_line_start.
// Backpressure: VGA_re held until the first VGA_we; a new line start during a fetch only flags overrun_err.
// Option: define VGA_ROW_BUFFER_LINE_DOUBLE_EN to show each VRAM row on two screen lines.
`include "screen_settings.vh"

module vga_row_buffer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_line_start,
    input  logic [9:0]  scan_y,
    input  logic [9:0]  scan_x,
    input  logic        disp_en,
    input  logic [8:0]  y_tl,
    output logic        VGA_re,
    output logic [8:0]  VGA_y,
    input  logic        VGA_we,
    input  logic [9:0]  VGA_x,
    input  logic [23:0] VGA_data,
    output logic [23:0] pix_out,
    output logic        fetch_busy,
    output logic        overrun_err
);

    fetch_state_t state_q, state_d;
    logic         wr_sel;
    logic [9:0]   n_next, t_row, row;
    logic         req_ok, swap_ok, start_idle, fill_we;
    logic         pix_vld_q, rd_sel_q;
    pixel_t       rdata0, rdata1;

    // Line arithmetic: next line and fetch target, wrapped explicitly at the frame height.
    always_comb begin
        n_next = (scan_y >= 10'(`V_TOTAL - 1)) ? 10'd0 : scan_y + 10'd1;
        t_row  = (scan_y >= 10'(`V_TOTAL - 2)) ? scan_y - 10'(`V_TOTAL - 2) : scan_y + 10'd2;
`ifdef VGA_ROW_BUFFER_LINE_DOUBLE_EN
        row     = {1'b0, t_row[9:1]};
        req_ok  = (t_row < 10'(`SCREEN_H)) && !t_row[0];
        swap_ok = (n_next < 10'(`SCREEN_H)) && !n_next[0];
`else
        row     = t_row;
        req_ok  = t_row < 10'(`SCREEN_H);
        swap_ok = n_next < 10'(`SCREEN_H);
`endif
    end

    assign start_idle = scan_line_start && (state_q == ST_IDLE);
    assign fill_we    = VGA_we && (state_q != ST_IDLE) && (VGA_x < 10'(`SCREEN_W));
    assign VGA_re     = (state_q == ST_REQ);
    assign fetch_busy = (state_q != ST_IDLE);

    // Fetch FSM next state: request, wait for first write, fill until last column.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_idle && req_ok) state_d = ST_REQ;
            ST_REQ:  if (VGA_we) state_d = (VGA_x == LAST_X) ? ST_IDLE : ST_FILL;
            ST_FILL: if (VGA_we && (VGA_x == LAST_X)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, bank select, requested row and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_sel      <= 1'b0;
            VGA_y       <= 9'd0;
            overrun_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_idle && swap_ok) begin
                wr_sel <= ~wr_sel;
            end
            if (start_idle && req_ok) begin
                VGA_y <= 9'({1'b0, y_tl} + row);
            end
            if (scan_line_start && (state_q != ST_IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

    // Scanout qualifiers, aligned with the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_vld_q <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            pix_vld_q <= disp_en && (scan_x < 10'(`SCREEN_W));
            rd_sel_q  <= ~wr_sel;
        end
    end

    assign pix_out = pix_vld_q ? (rd_sel_q ? rdata1 : rdata0) : 24'd0;

    vga_line_ram u_bank0 (
        .clk   (clk),
        .we    (fill_we && !wr_sel),
        .waddr (VGA_x),
        .wdata (VGA_data),
        .raddr (scan_x),
        .rdata (rdata0)
    );

    vga_line_ram u_bank1 (
        .clk   (clk),
        .we    (fill_we && wr_sel),
        .waddr (VGA_x),
        .wdata (VGA_data),
        .raddr (scan_x),
        .rdata (rdata1)
    );

endmodule
